mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_array.sv | 29 ++
 rtl/mem_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and width helpers for the wait-state memory controller.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int unsigned WAIT_STATES_MAX = 15;
    localparam int unsigned CNT_W           = $clog2(WAIT_STATES_MAX + 1);

    // Byte-lane index width; never below one bit.
    function automatic int unsigned bsel_w(input int unsigned data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
    endfunction

    // Word-index width for a storage of the given depth; never below one bit.
    function automatic int unsigned word_aw(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage with per-byte-lane write enables and an asynchronous read port.
// Contents survive reset.
module mem_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WORDS  = 128,
    parameter int unsigned AW     = 7
) (
    input  logic                  clk,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NB; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_ctrl.sv
// Single-port memory controller with programmable wait states and byte access.
// Define MEM_CTRL_BOUNDS_ERR_EN to flag out-of-range addresses instead of wrapping them.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned MEM_BYTES   = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        write_enable,
    input  logic                        byte_enable,
    input  logic [bsel_w(DATA_W)-1:0]   byte_select,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           data_in,
    output logic [DATA_W-1:0]           data_out,
    output logic                        mem_wait,
    output logic                        err
);

    localparam int unsigned NB        = DATA_W / 8;
    localparam int unsigned BSEL_W    = bsel_w(DATA_W);
    localparam int unsigned MEM_WORDS = MEM_BYTES / NB;
    localparam int unsigned MAW       = word_aw(MEM_WORDS);

    typedef struct packed {
        logic              wr;
        logic              byte_en;
        logic [BSEL_W-1:0] lane_sel;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              accept, done, oob;
    req_t              req_live, req_q, req_act;
    logic [BSEL_W-1:0] lane;
    logic [NB-1:0]     wr_be;
    logic [DATA_W-1:0] wr_data, rd_word, rd_data;

    assign req_live = '{wr: write_enable, byte_en: byte_enable, lane_sel: byte_select,
                        adr: addr, wdata: data_in};

    // Zero wait states complete on the accept edge from live inputs; otherwise from the capture.
    assign req_act  = (state == IDLE) ? req_live : req_q;
    assign lane     = BSEL_W'(32'(req_act.lane_sel) % NB);
    assign mem_wait = (state == WAIT);

    // Next-state and completion decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        done = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MEM_CTRL_BOUNDS_ERR_EN
    localparam logic [ADDR_W:0] MEM_WORDS_A = (ADDR_W + 1)'(MEM_WORDS);

    assign oob = ({1'b0, req_act.adr} >= MEM_WORDS_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= done & oob;
        end
    end
`else
    assign oob = 1'b0;
    assign err = 1'b0;
`endif

    // Byte writes replicate the low byte so only the enabled lane matters.
    assign wr_data = req_act.byte_en ? {NB{req_act.wdata[7:0]}} : req_act.wdata;

    always_comb begin
        wr_be = '0;
        if (done && req_act.wr && !oob) begin
            wr_be = req_act.byte_en ? (NB'(1) << lane) : '1;
        end
    end

    always_comb begin
        rd_data = req_act.byte_en ? DATA_W'(rd_word[{lane, 3'b000} +: 8]) : rd_word;
        if (oob) begin
            rd_data = '0;
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .WORDS  (MEM_WORDS),
        .AW     (MAW)
    ) u_mem_array (
        .clk   (clk),
        .we    (wr_be),
        .addr  (MAW'(req_act.adr)),
        .wdata (wr_data),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            req_q    <= '0;
            data_out <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                req_q <= req_live;
            end
            if (done && !req_act.wr) begin
                data_out <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: three instances (0, 2 and 3 wait states) against an array model.
module tb_mem_ctrl;

`ifdef MEM_CTRL_BOUNDS_ERR_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n   [3];
    logic        en      [3];
    logic        we      [3];
    logic        be      [3];
    logic [0:0]  bsel    [3];
    logic [15:0] addr    [3];
    logic [15:0] din     [3];
    logic [15:0] dout    [3];
    logic        mw      [3];
    logic        err     [3];

    logic [15:0] model    [3][128];
    logic [15:0] exp_dout [3];
    int          checks = 0;
    int          fails  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_ctrl #(
            .DATA_W      (16),
            .ADDR_W      (16),
            .MEM_BYTES   (256),
            .WAIT_STATES ((g == 0) ? 2 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[g]),
            .en           (en[g]),
            .write_enable (we[g]),
            .byte_enable  (be[g]),
            .byte_select  (bsel[g]),
            .addr         (addr[g]),
            .data_in      (din[g]),
            .data_out     (dout[g]),
            .mem_wait     (mw[g]),
            .err          (err[g])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One access on instance k, started just after a rising edge; scramble perturbs
    // the held request during the wait cycles, which the controller must ignore.
    task automatic access(input int k, input bit wr, input bit ben, input bit bs,
                          input logic [15:0] a, input logic [15:0] d, input bit scramble);
        int          waits;
        bit          oob_e;
        logic [15:0] word;
        en[k] = 1'b1; we[k] = wr; be[k] = ben; bsel[k] = bs; addr[k] = a; din[k] = d;
        oob_e = BOUNDS && (a >= 16'd128);
        @(posedge clk); #1;
        waits = 0;
        while (mw[k] === 1'b1 && waits < 20) begin
            waits++;
            if (scramble) begin
                addr[k] = 16'($urandom); din[k] = 16'($urandom);
                we[k] = 1'($urandom); be[k] = 1'($urandom); bsel[k] = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        en[k] = 1'b0;
        chk("wait_cycles", 32'(waits), 32'(ws_of(k)));
        word = model[k][a[6:0]];
        if (wr) begin
            if (!oob_e) begin
                if (ben) model[k][a[6:0]][8*bs +: 8] = d[7:0];
                else     model[k][a[6:0]] = d;
            end
        end else begin
            exp_dout[k] = oob_e ? 16'h0 : (ben ? {8'h0, word[8*bs +: 8]} : word);
        end
        chk("data_out", 32'(dout[k]), 32'(exp_dout[k]));
        chk("err", 32'(err[k]), 32'(oob_e));
    endtask

    task automatic rand_access(input int k);
        logic [15:0] a;
        a = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 255));
        access(k, 1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), ws_of(k) > 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; en[k] = 1'b0; we[k] = 1'b0; be[k] = 1'b0;
            bsel[k] = 1'b0; addr[k] = '0; din[k] = '0; exp_dout[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_data_out", 32'(dout[k]), 32'h0);
            chk("rst_mem_wait", 32'(mw[k]), 32'h0);
            chk("rst_err", 32'(err[k]), 32'h0);
            rst_n[k] = 1'b1;
        end

        // Fill every word so the model never depends on file contents.
        fork
            for (int i = 0; i < 128; i++) access(0, 1'b1, 1'b0, 1'b0, 16'(i), 16'($urandom), 1'b0);
            for (int i = 0; i < 128; i++) access(1, 1'b1, 1'b0, 1'b0, 16'(i), 16'($urandom), 1'b0);
            for (int i = 0; i < 128; i++) access(2, 1'b1, 1'b0, 1'b0, 16'(i), 16'($urandom), 1'b0);
        join

        // Two-wait-state write then read back.
        access(0, 1'b1, 1'b0, 1'b0, 16'd3, 16'hBEEF, 1'b0);
        access(0, 1'b0, 1'b0, 1'b0, 16'd3, 16'h0, 1'b0);
        chk("beef_read", 32'(dout[0]), 32'h0000_BEEF);

        // Byte lanes.
        access(0, 1'b1, 1'b0, 1'b0, 16'd5, 16'h1234, 1'b0);
        access(0, 1'b1, 1'b1, 1'b1, 16'd5, 16'h99AB, 1'b0);
        access(0, 1'b0, 1'b0, 1'b0, 16'd5, 16'h0, 1'b0);
        chk("byte_merge", 32'(dout[0]), 32'h0000_AB34);
        access(0, 1'b0, 1'b1, 1'b0, 16'd5, 16'h0, 1'b0);
        chk("byte_read", 32'(dout[0]), 32'h0000_0034);

        // Requests changing during the wait are ignored.
        access(0, 1'b1, 1'b0, 1'b0, 16'd9, 16'hC0DE, 1'b1);
        access(0, 1'b0, 1'b0, 1'b0, 16'd9, 16'h0, 1'b1);
        chk("held_req", 32'(dout[0]), 32'h0000_C0DE);

        // Out-of-range address: flagged, or wrapped onto word 72.
        access(0, 1'b1, 1'b0, 1'b0, 16'd72, 16'h7272, 1'b0);
        access(0, 1'b0, 1'b0, 1'b0, 16'd200, 16'h0, 1'b0);
        chk("oob_read", 32'(dout[0]), BOUNDS ? 32'h0 : 32'h0000_7272);
        @(posedge clk); #1;
        chk("err_one_cycle", 32'(err[0]), 32'h0);

        // Zero wait states, back-to-back reads.
        access(1, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0, 1'b0);
        access(1, 1'b0, 1'b0, 1'b0, 16'd1, 16'h0, 1'b0);
        chk("zws_no_wait", 32'(mw[1]), 32'h0);

        // Reset in the second wait cycle aborts the write.
        en[2] = 1'b1; we[2] = 1'b1; be[2] = 1'b0; bsel[2] = 1'b0; addr[2] = 16'd7; din[2] = 16'h5555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_wait", 32'(mw[2]), 32'h1);
        rst_n[2] = 1'b0;
        en[2] = 1'b0;
        #1;
        chk("mid_rst_data_out", 32'(dout[2]), 32'h0);
        chk("mid_rst_mem_wait", 32'(mw[2]), 32'h0);
        chk("mid_rst_err", 32'(err[2]), 32'h0);
        exp_dout[2] = '0;
        @(posedge clk); #1;
        rst_n[2] = 1'b1;
        access(2, 1'b0, 1'b0, 1'b0, 16'd7, 16'h0, 1'b0);

        // Randomized traffic on every instance.
        for (int n = 0; n < 150; n++) rand_access(0);
        for (int n = 0; n < 100; n++) rand_access(1);
        for (int n = 0; n < 60; n++)  rand_access(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
